adc_responder: RTL and testbench

ADC_RESPONDER -- requirements
Module: adc_responder

---
 rtl/adc_responder.sv | 153 +++++++++++++++
 tb/tb_adc_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/adc_responder.sv
// adc_responder: SPI-style ADC target model. Returns one of eight 12-bit samples per
// 16-clock frame, MSB first. The channel is selected by a 3-bit address received in the
// previous frame. All SPI pins are synchronized into the c50m domain. SCLK edges are found
// by comparing the synchronized level with a registered copy of it.
//
// Build option: define ADC_RESP_LOOPBACK_EN to replace the four leading zero bits of each
// frame with {1'b0, channel}. This lets the initiator check frame alignment.

module adc_responder (
    input  logic        c50m,
    input  logic        rst_n,
    input  logic        sclk_in,
    input  logic        cs_n_in,
    input  logic        din,
    input  logic [95:0] ch_data,
    output logic        dout,
    output logic [2:0]  cur_ch,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

`ifdef ADC_RESP_LOOPBACK_EN
    localparam bit LoopbackEn = 1'b1;
`else
    localparam bit LoopbackEn = 1'b0;
`endif

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    // Synchronizer stages plus SCLK history for edge detection
    logic sclk_s1, sclk_s2, sclk_q;
    logic cs_s1, cs_s2;
    logic din_s1, din_s2;

    logic sclk_rise, sclk_fall;

    state_e      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] tx_q, tx_d;
    logic [2:0]  cur_ch_q, cur_ch_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic [11:0] samples [8];

    for (genvar k = 0; k < 8; k++) begin : g_samples
        assign samples[k] = ch_data[12*k +: 12];
    end

    // Word loaded into the shift register at the start of each frame
    function automatic logic [15:0] tx_word(input logic [2:0] ch, input logic [11:0] sample);
        return LoopbackEn ? {1'b0, ch, sample} : {4'b0000, sample};
    endfunction

    // Two-flop synchronizers for all SPI pins; reset to the bus idle levels
    always_ff @(posedge c50m) begin
        if (!rst_n) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_q  <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            din_s1  <= 1'b0;
            din_s2  <= 1'b0;
        end else begin
            sclk_s1 <= sclk_in;
            sclk_s2 <= sclk_s1;
            sclk_q  <= sclk_s2;
            cs_s1   <= cs_n_in;
            cs_s2   <= cs_s1;
            din_s1  <= din;
            din_s2  <= din_s1;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_q;
    assign sclk_fall = ~sclk_s2 & sclk_q;

    // State and datapath registers
    always_ff @(posedge c50m) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            bit_cnt_q    <= 4'd0;
            addr_q       <= 3'd0;
            tx_q         <= 16'd0;
            cur_ch_q     <= 3'd0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            addr_q       <= addr_d;
            tx_q         <= tx_d;
            cur_ch_q     <= cur_ch_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    // Next-state logic: frame start, bit counting, address capture, shifting, abort
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        addr_d       = addr_q;
        tx_d         = tx_q;
        cur_ch_d     = cur_ch_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (!cs_s2) begin
                    state_d   = StActive;
                    bit_cnt_d = 4'd0;
                    tx_d      = tx_word(cur_ch_q, samples[cur_ch_q]);
                end
            end
            StActive: begin
                if (cs_s2) begin
                    // Abort wins over any SCLK edge seen in the same cycle
                    state_d   = StIdle;
                    bit_cnt_d = 4'd0;
                end else if (sclk_rise) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    case (bit_cnt_q)
                        4'd2:  addr_d[2] = din_s2;
                        4'd3:  addr_d[1] = din_s2;
                        4'd4:  addr_d[0] = din_s2;
                        4'd15: begin
                            // End of frame: the address just received selects the next word
                            cur_ch_d     = addr_q;
                            tx_d         = tx_word(addr_q, samples[addr_q]);
                            frame_done_d = 1'b1;
                            frame_cnt_d  = frame_cnt_q + 16'd1;
                        end
                        default: ;
                    endcase
                end else if (sclk_fall && (bit_cnt_q != 4'd0)) begin
                    // Holding at bit_cnt 0 keeps the MSB valid through the first rising edge
                    tx_d = {tx_q[14:0], 1'b0};
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign dout       = (state_q == StActive) & tx_q[15];
    assign cur_ch     = cur_ch_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_adc_responder.sv
// Directed testbench for adc_responder. Acts as the SPI initiator at 1 MHz, with SCLK idling
// low and 25 c50m cycles per SCLK phase. It checks returned words, channel tracking, frame
// counting, frame abort, and reset.

module tb_adc_responder;

`ifdef ADC_RESP_LOOPBACK_EN
    localparam bit LoopEn = 1'b1;
`else
    localparam bit LoopEn = 1'b0;
`endif

    localparam int Half = 25;

    logic        c50m = 1'b0;
    logic        rst_n;
    logic        sclk_in;
    logic        cs_n_in;
    logic        din;
    logic [95:0] ch_data;
    logic        dout;
    logic [2:0]  cur_ch;
    logic        frame_done;
    logic [15:0] frame_cnt;

    int checks   = 0;
    int failures = 0;
    int fd_count = 0;

    adc_responder dut (
        .c50m       (c50m),
        .rst_n      (rst_n),
        .sclk_in    (sclk_in),
        .cs_n_in    (cs_n_in),
        .din        (din),
        .ch_data    (ch_data),
        .dout       (dout),
        .cur_ch     (cur_ch),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #10 c50m = ~c50m;

    // Count frame_done pulses; each pulse is one c50m cycle wide
    always @(negedge c50m) begin
        if (frame_done === 1'b1) fd_count <= fd_count + 1;
    end

    initial begin
        #10ms;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [11:0] get_ch(input int k);
        return ch_data[12*k +: 12];
    endfunction

    function automatic logic [15:0] exp_word(input logic [2:0] ch, input logic [11:0] s);
        return LoopEn ? {1'b0, ch, s} : {4'b0000, s};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Run nbits SCLK periods and capture dout just before each rising edge. At the
    // start of bit chg_bit, channel 2 is overwritten with 12'hFFF.
    task automatic spi_bits(input logic [2:0] addr, input int nbits, input int chg_bit,
                            output logic [15:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_bit) ch_data[24 +: 12] = 12'hFFF;
            case (i)
                2:       din = addr[2];
                3:       din = addr[1];
                4:       din = addr[0];
                default: din = 1'($urandom_range(0, 1));
            endcase
            repeat (Half) @(negedge c50m);
            rx[15 - i] = dout;
            sclk_in = 1'b1;
            repeat (Half) @(negedge c50m);
            sclk_in = 1'b0;
        end
        din = 1'b0;
    endtask

    initial begin
        logic [15:0] rx;
        logic [2:0]  prev;
        logic [2:0]  a;
        int          fd0;

        sclk_in = 1'b0;
        cs_n_in = 1'b1;
        din     = 1'b0;
        rst_n   = 1'b0;
        ch_data = {12'h777, 12'h001, 12'hA5C, 12'h444, 12'h333, 12'h123, 12'h111, 12'h0F0};
        repeat (3) @(negedge c50m);

        // Reset values
        check("rst_dout", {15'd0, dout}, 16'd0);
        check("rst_cur_ch", {13'd0, cur_ch}, 16'd0);
        check("rst_frame_done", {15'd0, frame_done}, 16'd0);
        check("rst_frame_cnt", frame_cnt, 16'd0);

        // Address 5 in frame 0; frame 1 returns channel 5
        rst_n = 1'b1;
        repeat (2) @(negedge c50m);
        cs_n_in = 1'b0;
        spi_bits(3'd5, 16, -1, rx);
        check("f0_data", rx, exp_word(3'd0, 12'h0F0));
        check("f0_cur_ch", {13'd0, cur_ch}, 16'd5);
        spi_bits(3'd0, 16, -1, rx);
        check("f1_data", rx, exp_word(3'd5, 12'hA5C));
        check("f1_frame_cnt", frame_cnt, 16'd2);

        // Ten back-to-back frames from a fresh reset, cs_n held low
        cs_n_in = 1'b1;
        repeat (5) @(negedge c50m);
        rst_n = 1'b0;
        @(negedge c50m);
        rst_n = 1'b1;
        cs_n_in = 1'b0;
        repeat (3) @(negedge c50m);
        fd0  = fd_count;
        prev = 3'd0;
        for (int i = 0; i < 10; i++) begin
            a = 3'(i % 8);
            spi_bits(a, 16, -1, rx);
            check($sformatf("b2b_data_%0d", i), rx, exp_word(prev, get_ch(int'(prev))));
            prev = a;
        end
        check("b2b_pulses", 16'(fd_count - fd0), 16'd10);
        check("b2b_frame_cnt", frame_cnt, 16'd10);
        check("b2b_cur_ch", {13'd0, cur_ch}, 16'd1);

        // Mid-frame change of ch_data[2] must not disturb the word in flight
        spi_bits(3'd2, 16, -1, rx);
        check("pre_chg_data", rx, exp_word(3'd1, 12'h111));
        spi_bits(3'd3, 16, 8, rx);
        check("chg_data", rx, exp_word(3'd2, 12'h123));
        ch_data[24 +: 12] = 12'h123;

        // Abort after 7 rising edges
        fd0 = fd_count;
        spi_bits(3'd6, 7, -1, rx);
        cs_n_in = 1'b1;
        repeat (8) @(negedge c50m);
        check("abort_pulses", 16'(fd_count - fd0), 16'd0);
        check("abort_frame_cnt", frame_cnt, 16'd12);
        check("abort_dout", {15'd0, dout}, 16'd0);
        check("abort_cur_ch", {13'd0, cur_ch}, 16'd3);
        cs_n_in = 1'b0;
        spi_bits(3'd0, 16, -1, rx);
        check("post_abort_data", rx, exp_word(3'd3, 12'h333));
        check("post_abort_frame_cnt", frame_cnt, 16'd13);

        // One-cycle reset at bit_cnt 10
        spi_bits(3'd4, 10, -1, rx);
        rst_n = 1'b0;
        @(negedge c50m);
        rst_n = 1'b1;
        check("midrst_dout", {15'd0, dout}, 16'd0);
        check("midrst_cur_ch", {13'd0, cur_ch}, 16'd0);
        check("midrst_frame_done", {15'd0, frame_done}, 16'd0);
        check("midrst_frame_cnt", frame_cnt, 16'd0);
        cs_n_in = 1'b1;
        repeat (5) @(negedge c50m);
        cs_n_in = 1'b0;
        spi_bits(3'd6, 16, -1, rx);
        check("postrst_data", rx, exp_word(3'd0, 12'h0F0));
        check("postrst_cur_ch", {13'd0, cur_ch}, 16'd6);
        check("postrst_frame_cnt", frame_cnt, 16'd1);

        // Address 6 was sent above; ch_data[6] = 12'h001
        spi_bits(3'd0, 16, -1, rx);
        check("ch6_data", rx, LoopEn ? 16'h6001 : 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
